// File: rtl/neuron_layer_driver.sv
// neuron_layer_driver
// Drives one layer of free-running fixed-point neurons that share one input
// vector. Input vectors are presented on the fixed neuron pass boundary. The
// bias-only priming pass after reset is discarded. Captured output vectors are
// queued in a 2-entry FIFO that drains on a valid/ready stream.
// Optional build macro NEURON_LAYER_ARGMAX_EN adds out_class. out_class is the
// index of the largest signed output element, computed when the vector is
// pushed and stored with each FIFO entry.
module neuron_layer_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int N_IN       = 4,
    parameter int N_OUT      = 3,
    parameter int PASS_LEN   = 7,
    localparam int CLASS_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN*DATA_WIDTH-1:0]  in_data,
    output logic                        neuron_en,
    output logic                        neuron_run,
    output logic [N_IN*DATA_WIDTH-1:0]  neuron_x,
    input  logic [N_OUT*DATA_WIDTH-1:0] neuron_y,
    output logic                        out_valid,
    input  logic                        out_ready,
`ifdef NEURON_LAYER_ARGMAX_EN
    output logic [CLASS_W-1:0]          out_class,
`endif
    output logic [N_OUT*DATA_WIDTH-1:0] out_data
);

    localparam int PHASE_W = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PASS_LEN - 1);

    typedef enum logic [1:0] {
        RESET_WAIT,
        PRIME,
        RUN
    } state_t;

    state_t                        state_q, state_d;
    logic [PHASE_W-1:0]            phase_q, phase_d;
    logic                          primed_q, primed_d;
    logic                          inflight_q, inflight_d;
    logic                          run_q, run_d;
    logic [N_IN*DATA_WIDTH-1:0]    x_q, x_d;
    logic [1:0]                    count_q, count_d;
    logic                          wr_ptr_q, wr_ptr_d;
    logic                          rd_ptr_q, rd_ptr_d;
    logic [N_OUT*DATA_WIDTH-1:0]   mem_q [2];
    logic [N_OUT*DATA_WIDTH-1:0]   mem_d [2];

    logic       last_phase;
    logic       pop;
    logic       push;
    logic       accept;
    logic [2:0] credit_used;

    // Pass boundary: the neuron output-valid cycle, which is also the cycle
    // before the neurons load their next input.
    assign last_phase  = (state_q == RUN) && (phase_q == LAST_PHASE);
    assign out_valid   = (count_q != 2'd0);
    assign pop         = out_valid && out_ready;
    // Slots already promised: queued entries plus the sample being computed,
    // less whatever leaves on this edge. One free slot is needed to accept.
    assign credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign in_ready    = last_phase && (credit_used <= 3'd1);
    assign accept      = in_valid && in_ready;
    assign push        = last_phase && primed_q && inflight_q;

    assign neuron_en   = run_q;
    assign neuron_run  = run_q;
    assign neuron_x    = x_q;
    assign out_data    = mem_q[rd_ptr_q];

    // Sequencer next state: start-up, priming, and the free-running pass counter
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        primed_d   = primed_q;
        inflight_d = inflight_q;
        run_d      = run_q;
        x_d        = accept ? in_data : x_q;
        case (state_q)
            RESET_WAIT: begin
                run_d   = 1'b1;
                state_d = PRIME;
            end
            PRIME: begin
                phase_d = '0;
                state_d = RUN;
            end
            RUN: begin
                if (last_phase) begin
                    phase_d    = '0;
                    primed_d   = 1'b1;
                    inflight_d = accept;
                end else begin
                    phase_d = phase_q + PHASE_W'(1);
                end
            end
            default: begin
                state_d = RESET_WAIT;
            end
        endcase
    end

    // FIFO next state: write on capture, advance the head on pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = neuron_y;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Sequencer and FIFO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_WAIT;
            phase_q    <= '0;
            primed_q   <= 1'b0;
            inflight_q <= 1'b0;
            run_q      <= 1'b0;
            x_q        <= '0;
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            primed_q   <= primed_d;
            inflight_q <= inflight_d;
            run_q      <= run_d;
            x_q        <= x_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

`ifdef NEURON_LAYER_ARGMAX_EN
    logic signed [DATA_WIDTH-1:0] y_elem [N_OUT];
    logic [CLASS_W-1:0]           best_idx;
    logic [CLASS_W-1:0]           class_q [2];
    logic [CLASS_W-1:0]           class_d [2];

    // Split the packed neuron outputs into signed elements
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_y_elem
        assign y_elem[gi] = neuron_y[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Argmax: strict greater-than keeps the lowest index on ties
    always_comb begin
        logic signed [DATA_WIDTH-1:0] best_val;
        best_idx = '0;
        best_val = y_elem[0];
        for (int i = 1; i < N_OUT; i++) begin
            if (y_elem[i] > best_val) begin
                best_val = y_elem[i];
                best_idx = CLASS_W'(i);
            end
        end
    end

    // Class storage next state, written alongside the data entry
    always_comb begin
        class_d = class_q;
        if (push) begin
            class_d[wr_ptr_q] = best_idx;
        end
    end

    // Class storage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            class_q <= '{default: '0};
        end else begin
            class_q <= class_d;
        end
    end

    assign out_class = class_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_neuron_layer_driver.sv
// Directed testbench for neuron_layer_driver. The neuron layer is modelled as
// Y_k = X0 + k, or as a fixed override vector for the argmax checks.
`timescale 1ns/1ps
module tb_neuron_layer_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        neuron_en;
    logic        neuron_run;
    logic [31:0] neuron_x;
    logic [23:0] neuron_y;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] out_data;
`ifdef NEURON_LAYER_ARGMAX_EN
    logic [1:0]  out_class;
`endif

    int compared   = 0;
    int mismatched = 0;
    int cyc;

    logic        ovr_en = 1'b0;
    logic [23:0] ovr_y  = '0;
    logic [7:0]  x0;

    always #5 clk = ~clk;

    // Cycle index: 1 is the first cycle after reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    assign x0       = neuron_x[7:0];
    assign neuron_y = ovr_en ? ovr_y : {x0 + 8'd2, x0 + 8'd1, x0};

    neuron_layer_driver dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .neuron_en  (neuron_en),
        .neuron_run (neuron_run),
        .neuron_x   (neuron_x),
        .neuron_y   (neuron_y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef NEURON_LAYER_ARGMAX_EN
        .out_class  (out_class),
`endif
        .out_data   (out_data)
    );

    function automatic logic [23:0] exp_y(input logic [7:0] v);
        return {v + 8'd2, v + 8'd1, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ovr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef NEURON_LAYER_ARGMAX_EN
    task automatic run_class(input string tag, input logic [23:0] y, input logic [1:0] exp_cls);
        do_reset();
        ovr_en = 1'b1;
        ovr_y  = y;
        go_to(8);
        in_valid = 1'b1;
        in_data  = 32'h0403_0201;
        tick();
        in_valid = 1'b0;
        go_to(16);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, y);
        chk(tag, out_class, exp_cls);
    endtask
`endif

    logic [31:0] vec [3];
    logic [7:0]  vx0 [3];
    int idx;
    int oidx;

    initial begin
        // ---- Reset values while rst is held ----
        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_neuron_en", neuron_en, 1'b0);
        chk("rst_neuron_run", neuron_run, 1'b0);
        chk("rst_neuron_x", neuron_x, 32'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 24'h0);

        // ---- Reset release, no input: run rises at cycle 1, phase 6 every 7 ----
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            go_to(c);
            chk("idle_run", neuron_run, 1'b1);
            chk("idle_en", neuron_en, 1'b1);
            chk("idle_in_ready", in_ready, (c >= 2) && (((c - 2) % 7) == 6));
            chk("idle_out_valid", out_valid, 1'b0);
        end

        // ---- Single vector: accept at 8, output at 16 ----
        do_reset();
        go_to(8);
        in_valid = 1'b1;
        in_data  = {8'd1, 8'd2, 8'd3, 8'd4};
        chk("single_accept", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("single_neuron_x", neuron_x, {8'd1, 8'd2, 8'd3, 8'd4});
        go_to(15);
        chk("single_early", out_valid, 1'b0);
        go_to(16);
        chk("single_valid", out_valid, 1'b1);
        chk("single_data", out_data, {8'd6, 8'd5, 8'd4});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_popped", out_valid, 1'b0);

        // ---- Three vectors back-to-back with out_ready high ----
        vx0[0] = 8'd10;  vx0[1] = 8'hEC;  vx0[2] = 8'd50;
        vec[0] = {8'd7, 8'd7, 8'd7, vx0[0]};
        vec[1] = {8'd9, 8'd8, 8'd7, vx0[1]};
        vec[2] = {8'd1, 8'd1, 8'd1, vx0[2]};
        do_reset();
        idx  = 0;
        oidx = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = vec[0];
        while (cyc <= 36) begin
            if (out_valid) begin
                if (oidx < 3) begin
                    chk("b2b_out_cycle", cyc, 16 + 7 * oidx);
                    chk("b2b_out_data", out_data, exp_y(vx0[oidx]));
                end else begin
                    chk("b2b_out_extra", oidx, 2);
                end
                oidx++;
            end
            if (in_valid && in_ready) begin
                chk("b2b_accept_cycle", cyc, 8 + 7 * idx);
                idx++;
            end
            tick();
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? vec[idx] : 32'h0;
        end
        chk("b2b_accepts", idx, 3);
        chk("b2b_outputs", oidx, 3);
        out_ready = 1'b0;

        // ---- Backpressure: FIFO fills, C waits for a free slot ----
        do_reset();
        go_to(8);
        in_valid = 1'b1;
        in_data  = {8'd0, 8'd0, 8'd0, 8'd20};
        chk("bp_accept_a", in_ready, 1'b1);
        tick();
        in_data = {8'd0, 8'd0, 8'd0, 8'd40};
        go_to(15);
        chk("bp_accept_b", in_ready, 1'b1);
        tick();
        in_data = {8'd0, 8'd0, 8'd0, 8'd60};
        go_to(22);
        chk("bp_block_22", in_ready, 1'b0);
        go_to(29);
        chk("bp_block_29", in_ready, 1'b0);
        chk("bp_head_a", out_data, exp_y(8'd20));
        go_to(30);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_valid_b", out_valid, 1'b1);
        chk("bp_head_b", out_data, exp_y(8'd40));
        go_to(36);
        chk("bp_accept_c", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        go_to(40);
        out_ready = 1'b1;
        tick();
        chk("bp_empty", out_valid, 1'b0);
        tick();
        out_ready = 1'b0;
        chk("bp_empty_pop", out_valid, 1'b0);
        go_to(43);
        chk("bp_c_early", out_valid, 1'b0);
        go_to(44);
        chk("bp_valid_c", out_valid, 1'b1);
        chk("bp_head_c", out_data, exp_y(8'd60));

        // ---- Reset mid-operation at phase 3 ----
        do_reset();
        go_to(8);
        in_valid = 1'b1;
        in_data  = {8'd0, 8'd0, 8'd0, 8'd70};
        chk("mid_accept_p", in_ready, 1'b1);
        tick();
        in_data = {8'd0, 8'd0, 8'd0, 8'd80};
        go_to(15);
        chk("mid_accept_q", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        go_to(19);
        chk("mid_fifo_p", out_data, exp_y(8'd70));
        rst = 1'b1;
        #1;
        chk("mid_rst_run", neuron_run, 1'b0);
        chk("mid_rst_en", neuron_en, 1'b0);
        chk("mid_rst_x", neuron_x, 32'h0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, 24'h0);
        chk("mid_rst_ready", in_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        go_to(1);
        chk("mid_rerun", neuron_run, 1'b1);
        go_to(8);
        in_valid = 1'b1;
        in_data  = {8'd0, 8'd0, 8'd0, 8'd90};
        chk("mid_accept_r", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        while (cyc < 16) begin
            chk("mid_no_stale", out_valid, 1'b0);
            tick();
        end
        chk("mid_valid_r", out_valid, 1'b1);
        chk("mid_data_r", out_data, exp_y(8'd90));

`ifdef NEURON_LAYER_ARGMAX_EN
        // ---- Argmax class ----
        run_class("cls_tie", {8'd5, 8'hFE, 8'd5}, 2'd0);
        run_class("cls_last", {8'd7, 8'hFD, 8'hFF}, 2'd2);
        run_class("cls_zero", 24'h0, 2'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
